pwm_fade_ctrl: RTL and testbench
================================

# pwm_fade_ctrl

Duty-cycle fade controller sitting directly upstream of the PWM driver. It accepts a target duty value from the register/CPU side and moves the driver's cutoff toward that target one LSB per step, at a programmable step rate. Each new level is delivered as a one-cycle `set_cutoff_en` pulse with `cutoff_value`, which maps 1:1 onto the PWM driver's update inputs. It also supports an immediate-jump mode and reports busy/done status.

## Interface

- `STEP_DIV`, 16'd1000: clock cycles per ramp step; legal range 1..65535.
- `RESET_LEVEL`, 8'h7f: level after reset; equals the PWM driver's reset cutoff.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `target_wr`  in  1  one-cycle strobe; latch `target_value` and `ramp_en`.
- `target_value`  in  8  requested duty level.
- `ramp_en`  in  1  sampled with `target_wr`; 1 = ramp, 0 = jump.
- `set_cutoff_en`  out  1  one-cycle update strobe to the PWM driver.
- `cutoff_value`  out  8  level delivered with `set_cutoff_en`; holds the current level at all times.
- `busy`  out  1  high while a ramp is in progress.
- `done`  out  1  one-cycle pulse when the final target level is delivered.

## Operation

- **States:** IDLE and RAMP. Internal registers are `level[7:0]`, `target[7:0]`, and prescaler `pres[15:0]`.
- **Reset** (while `reset` is low): state = IDLE, `level` = `target` = RESET_LEVEL, `pres` = 0.
  - Outputs: `cutoff_value` = RESET_LEVEL, `set_cutoff_en` = 0, `busy` = 0, `done` = 0.
  - No update pulse is emitted on reset exit.
- **IDLE + `target_wr`:**
  - If `ramp_en` = 0, or `target_value` = `level`: `level` <= `target_value`, and one `set_cutoff_en` pulse plus one `done` pulse are issued. State stays IDLE.
  - Otherwise: `target` <= `target_value`, `pres` <= 0, state -> RAMP.
- **RAMP:**
  - `pres` increments every cycle.
  - When `pres` = STEP_DIV-1 (tick): `pres` <= 0, and `level` moves ±1 toward `target`. Each tick emits one `set_cutoff_en` pulse.
  - On the tick where the new `level` = `target`: assert `done` and return to IDLE.
- **RAMP + `target_wr`:**
  - `target` and mode are re-latched and `pres` <= 0. No step occurs in that cycle, even if it was a tick cycle.
  - If the new mode is jump, or the new target equals `level`: behave as the IDLE jump case and go to IDLE.
  - Otherwise stay in RAMP; the direction is recomputed from the new target, so reversal mid-ramp is legal.
- **Arithmetic:**
  - `level` is 8-bit unsigned and only moves toward a target within 0..255, so no wrap or saturation can occur.
  - Comparisons are unsigned.
- **Downstream note:** every `set_cutoff_en` restarts the PWM driver's counter. STEP_DIV must be at least one full PWM period (256 PWM clocks) so that each level is visible.

## Timing

- All outputs are registered.
- **Jump latency:** `set_cutoff_en`, the new `cutoff_value`, and `done` are high in the cycle immediately after the `target_wr` edge.
- **Ramp cadence:**
  - The first `set_cutoff_en` appears STEP_DIV cycles after the `target_wr` edge; subsequent pulses are spaced exactly STEP_DIV cycles apart.
  - With STEP_DIV = 1, pulses occur on consecutive cycles.
  - An N-LSB ramp takes N·STEP_DIV cycles.
- **Output alignment:**
  - `cutoff_value` changes only in cycles where `set_cutoff_en` = 1, and holds otherwise.
  - `busy` rises the cycle after a ramping `target_wr`. It falls in the same cycle that `done` is high.
  - `done` coincides with the final `set_cutoff_en` pulse.
- **Asynchronous reset mid-ramp:** outputs take their reset values immediately. Any in-flight pulse is dropped.
- **`target_wr` held high for multiple cycles:** each cycle counts as a write, so `pres` is held at 0 and no steps occur until the strobe drops.

## Test plan

- **Reset values:** assert `reset` low mid-simulation -> `cutoff_value` = 0x7f, `busy` = `done` = `set_cutoff_en` = 0, with no pulse after release.
- **Jump:** `target_wr` with `target_value` = 0x20, `ramp_en` = 0 -> next cycle `set_cutoff_en` = 1, `cutoff_value` = 0x20, `done` = 1, `busy` = 0.
- **Ramp up** (STEP_DIV = 4): 0x7f -> 0x82 with `ramp_en` = 1.
  - Required: three pulses at +4, +8, +12 cycles with values 0x80, 0x81, 0x82.
  - `done` is high with the 0x82 pulse; `busy` is high from +1 through +11.
- **Retarget reversal** (STEP_DIV = 4): ramp 0x7f -> 0x90; after the 0x81 pulse, write 0x7e.
  - Required: the next pulse is 0x80, exactly 4 cycles after the write, followed by 0x7f and 0x7e, then `done`.
- **Equal target:** write `target_value` = current level with `ramp_en` = 1 -> one pulse carrying the same value, `done` = 1, and no RAMP entry.
- **Reset mid-ramp:** assert `reset` during a 0x7f -> 0xff ramp -> outputs return to reset values immediately, and no `set_cutoff_en` occurs until the next `target_wr`.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: moves the PWM driver cutoff toward a requested duty level
// one LSB per STEP_DIV clocks, or jumps straight to it. Each new level is
// delivered as a one-cycle set_cutoff_en strobe with cutoff_value.
module pwm_fade_ctrl #(
   parameter logic [15:0] STEP_DIV    = 16'd1000,
   parameter logic [7:0]  RESET_LEVEL = 8'h7f
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       target_wr,
   input  logic [7:0] target_value,
   input  logic       ramp_en,
   output logic       set_cutoff_en,
   output logic [7:0] cutoff_value,
   output logic       busy,
   output logic       done
);

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  level_reg, level_next;
   logic [7:0]  target_reg, target_next;
   logic [15:0] pres_reg, pres_next;
   logic        pulse_reg, pulse_next;
   logic        done_reg, done_next;
   logic        busy_reg, busy_next;
   logic        tick;
   logic [7:0]  step_level;

   // The prescaler wraps on the last cycle of each step period.
   assign tick = (pres_reg == (STEP_DIV - 16'd1));

   // One LSB toward the latched target; never wraps since the target bounds it.
   assign step_level = (target_reg > level_reg) ? (level_reg + 8'd1) : (level_reg - 8'd1);

   // Next-state and registered-output logic; a write always wins over a step.
   always_comb begin
      state_next  = state_reg;
      level_next  = level_reg;
      target_next = target_reg;
      pres_next   = pres_reg;
      pulse_next  = 1'b0;
      done_next   = 1'b0;

      if (target_wr) begin
         target_next = target_value;
         pres_next   = 16'd0;
         if (!ramp_en || (target_value == level_reg)) begin
            level_next = target_value;
            pulse_next = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
         end else begin
            state_next = RAMP;
         end
      end else if (state_reg == RAMP) begin
         if (tick) begin
            pres_next  = 16'd0;
            level_next = step_level;
            pulse_next = 1'b1;
            if (step_level == target_reg) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end else begin
            pres_next = pres_reg + 16'd1;
         end
      end

      busy_next = (state_next == RAMP);
   end

   // State and output registers; reset drops any pulse that was about to issue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         level_reg  <= RESET_LEVEL;
         target_reg <= RESET_LEVEL;
         pres_reg   <= 16'd0;
         pulse_reg  <= 1'b0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         level_reg  <= level_next;
         target_reg <= target_next;
         pres_reg   <= pres_next;
         pulse_reg  <= pulse_next;
         done_reg   <= done_next;
         busy_reg   <= busy_next;
      end
   end

   assign set_cutoff_en = pulse_reg;
   assign cutoff_value  = level_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Testbench for pwm_fade_ctrl with a short step period. Expected update
// pulses are queued when a write is issued and matched as the DUT emits them.
module tb_pwm_fade_ctrl;

   localparam logic [15:0] SD   = 16'd4;
   localparam int          SD_I = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       target_wr;
   logic [7:0] target_value;
   logic       ramp_en;
   logic       set_cutoff_en;
   logic [7:0] cutoff_value;
   logic       busy;
   logic       done;

   pwm_fade_ctrl #(.STEP_DIV(SD), .RESET_LEVEL(8'h7f)) dut (
      .clk          (clk),
      .reset        (reset),
      .target_wr    (target_wr),
      .target_value (target_value),
      .ramp_en      (ramp_en),
      .set_cutoff_en(set_cutoff_en),
      .cutoff_value (cutoff_value),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] val;
      logic       dn;
   } exp_t;

   typedef struct {
      logic       ramp;
      logic [7:0] val;
      logic [7:0] exp_final;
      int         exp_pulses;
   } vec_t;

   exp_t       sbq[$];
   int         checks    = 0;
   int         failures  = 0;
   int         pulse_cnt = 0;
   logic [7:0] last_cut  = 8'h7f;
   logic [7:0] model_level;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pulse monitor: matches every strobe against the queue and checks hold behaviour.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            last_cut = cutoff_value;
         end else begin
            if (set_cutoff_en) begin
               pulse_cnt++;
               if (sbq.size() == 0) begin
                  check("unexpected_pulse", 32'd1, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  check("pulse_cycle", cyc, e.cyc);
                  check("pulse_value", cutoff_value, e.val);
                  check("pulse_done", done, e.dn);
                  $display("pulse cyc=%0d value=0x%02h done=%0b", cyc, cutoff_value, done);
               end
            end else begin
               check("hold_value", cutoff_value, last_cut);
               check("done_without_pulse", done, 32'd0);
            end
            last_cut = cutoff_value;
         end
      end
   end

   // Issue a write held for 'hold' sampled edges; w is the cycle index of the last sampled edge.
   task automatic do_write(input logic [7:0] v, input logic r, input int hold, output int w);
      @(posedge clk);
      #1;
      target_wr    = 1'b1;
      target_value = v;
      ramp_en      = r;
      repeat (hold) @(posedge clk);
      #1;
      w         = cyc;
      target_wr = 1'b0;
      $display("write cyc=%0d value=0x%02h ramp=%0b hold=%0d", w, v, r, hold);
   endtask

   // Queue the expected pulses for a write; n_full is the full ramp length (0 for a jump).
   task automatic expect_pushes(input int w, input logic [7:0] v, input logic r,
                                input int max_steps, output int n_full);
      exp_t e;
      if (!r || (v == model_level)) begin
         n_full      = 0;
         model_level = v;
         e.cyc = w; e.val = v; e.dn = 1'b1;
         sbq.push_back(e);
      end else begin
         n_full = (v > model_level) ? int'(v - model_level) : int'(model_level - v);
         for (int k = 1; k <= n_full; k++) begin
            if (k <= max_steps) begin
               model_level = (v > model_level) ? model_level + 8'd1 : model_level - 8'd1;
               e.cyc = w + SD_I * k; e.val = model_level; e.dn = (model_level == v);
               sbq.push_back(e);
            end
         end
      end
   endtask

   // Wait for the queue to empty, checking busy along the way, under a cycle budget.
   task automatic drain(input int w, input int n_full);
      int budget = 0;
      do begin
         @(negedge clk);
         #1;
         if (n_full == 0 && cyc == w) check("busy_jump", busy, 32'd0);
         if (n_full > 0 && cyc > w) check("busy_ramp", busy, 32'(cyc < w + SD_I * n_full));
         budget++;
      end while (sbq.size() != 0 && budget < 200);
      if (sbq.size() != 0) begin
         check("drain_timeout", sbq.size(), 32'd0);
         sbq.delete();
      end
   endtask

   initial begin
      vec_t vecs[9];
      int   w, n, pc;

      vecs[0] = '{1'b1, 8'h82, 8'h82, 3};
      vecs[1] = '{1'b0, 8'h20, 8'h20, 1};
      vecs[2] = '{1'b1, 8'h23, 8'h23, 3};
      vecs[3] = '{1'b1, 8'h23, 8'h23, 1};
      vecs[4] = '{1'b1, 8'h21, 8'h21, 2};
      vecs[5] = '{1'b0, 8'hff, 8'hff, 1};
      vecs[6] = '{1'b1, 8'hfe, 8'hfe, 1};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 1};
      vecs[8] = '{1'b1, 8'h02, 8'h02, 2};

      reset        = 1'b0;
      target_wr    = 1'b0;
      target_value = 8'h00;
      ramp_en      = 1'b0;
      model_level  = 8'h7f;

      repeat (3) @(negedge clk);
      #1;
      check("rst_cutoff", cutoff_value, 32'h7f);
      check("rst_pulse", set_cutoff_en, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_done", done, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("no_pulse_on_reset_exit", pulse_cnt, 32'd0);

      // Table-driven writes from the reset level.
      for (int i = 0; i < 9; i++) begin
         pc = pulse_cnt;
         do_write(vecs[i].val, vecs[i].ramp, 1, w);
         expect_pushes(w, vecs[i].val, vecs[i].ramp, 255, n);
         drain(w, n);
         check("final_level", cutoff_value, vecs[i].exp_final);
         check("pulse_count", pulse_cnt - pc, vecs[i].exp_pulses);
      end

      // Retarget reversal: 0x7f toward 0x90, turned around to 0x7e after the 0x81 pulse.
      do_write(8'h7f, 1'b0, 1, w);
      expect_pushes(w, 8'h7f, 1'b0, 255, n);
      drain(w, n);
      do_write(8'h90, 1'b1, 1, w);
      expect_pushes(w, 8'h90, 1'b1, 2, n);
      drain(w, n);
      check("rev_mid_level", cutoff_value, 32'h81);
      do_write(8'h7e, 1'b1, 1, w);
      expect_pushes(w, 8'h7e, 1'b1, 255, n);
      drain(w, n);
      check("rev_final", cutoff_value, 32'h7e);

      // Write strobe held across several tick periods: no steps until it drops.
      pc = pulse_cnt;
      do_write(8'h85, 1'b1, 6, w);
      expect_pushes(w, 8'h85, 1'b1, 255, n);
      drain(w, n);
      check("held_final", cutoff_value, 32'h85);
      check("held_pulses", pulse_cnt - pc, 32'd7);

      // Reset mid-ramp 0x7f -> 0xff, asserted while an update pulse is showing.
      do_write(8'h7f, 1'b0, 1, w);
      expect_pushes(w, 8'h7f, 1'b0, 255, n);
      drain(w, n);
      do_write(8'hff, 1'b1, 1, w);
      expect_pushes(w, 8'hff, 1'b1, 2, n);
      drain(w, n);
      check("pre_reset_pulse", set_cutoff_en, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_cutoff", cutoff_value, 32'h7f);
      check("midrst_pulse", set_cutoff_en, 32'd0);
      check("midrst_busy", busy, 32'd0);
      check("midrst_done", done, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset       = 1'b1;
      model_level = 8'h7f;
      pc          = pulse_cnt;
      repeat (20) @(negedge clk);
      #1;
      check("no_pulse_after_reset", pulse_cnt - pc, 32'd0);
      check("post_reset_busy", busy, 32'd0);
      check("post_reset_cutoff", cutoff_value, 32'h7f);

      // Block responds normally after the reset.
      do_write(8'h20, 1'b0, 1, w);
      expect_pushes(w, 8'h20, 1'b0, 255, n);
      drain(w, n);
      check("post_reset_jump", cutoff_value, 32'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
